bus_interconnect: RTL and testbench



---
 rtl/bus_interconnect_if.sv | 30 +++
 rtl/bus_interconnect.sv | 170 +++++++++++++++++
 tb/tb_bus_interconnect.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_interconnect_if.sv
// CPU-side and slave-side bus signals of the interconnect, bundled for one connection.
interface bus_interconnect_if #(
    parameter int unsigned NSLAVES = 7
);
    logic [31:0]           m_addr;
    logic [31:0]           m_wdata;
    logic [3:0]            m_wmask;
    logic                  m_rstrb;
    logic [31:0]           m_rdata;
    logic                  m_rbusy;
    logic                  m_wbusy;
    logic [NSLAVES-1:0]    s_sel;
    logic [NSLAVES-1:0]    s_rstrb;
    logic [NSLAVES-1:0]    s_wr;
    logic [NSLAVES*32-1:0] s_rdata;
    logic [NSLAVES-1:0]    s_rbusy;
    logic [NSLAVES-1:0]    s_wbusy;

    // CPU plus peripherals: drive requests and slave responses.
    modport master (
        output m_addr, m_wdata, m_wmask, m_rstrb, s_rdata, s_rbusy, s_wbusy,
        input  m_rdata, m_rbusy, m_wbusy, s_sel, s_rstrb, s_wr
    );

    // The interconnect itself; write data goes straight to the slaves.
    modport slave (
        input  m_addr, m_wmask, m_rstrb, s_rdata, s_rbusy, s_wbusy,
        output m_rdata, m_rbusy, m_wbusy, s_sel, s_rstrb, s_wr
    );
endinterface

// File: rtl/bus_interconnect.sv
// Page decoder, registered read mux and busy merge between the CPU port and NSLAVES slaves,
// with busy timeout and a status page logging bus errors.
module bus_interconnect #(
    parameter int unsigned               NSLAVES     = 7,
    parameter int unsigned               PAGE_W      = 16,
    parameter logic [NSLAVES*PAGE_W-1:0] SLAVE_PAGES = {16'h0001, 16'h0044, 16'h0043, 16'h0042,
                                                        16'h0041, 16'h0040, 16'h0000},
    parameter logic [PAGE_W-1:0]         STATUS_PAGE = 16'h00FF,
    parameter int unsigned               TIMEOUT     = 255,
    parameter logic [31:0]               ERR_DATA    = 32'hDEADBEEF
) (
    input  logic                  clk,
    input  logic                  rst,
    bus_interconnect_if.slave     bus,
    output logic                  irq_err
);
    localparam int unsigned   SelW      = 5;
    localparam logic [SelW-1:0] SelStatus = 5'd16;
    localparam logic [SelW-1:0] SelUnmap  = 5'd17;
    localparam logic [SelW-1:0] SelErr    = 5'd18;

    typedef enum logic [1:0] {StIdle, StRwait, StWwait} state_e;

    state_e          state_q;
    logic [SelW-1:0] rsel_q, wsel_q;
    logic            rsel_a2_q;
    logic [15:0]     cnt_q;
    logic [31:0]     addr_q;
    logic [15:0]     err_count_q;
    logic [1:0]      last_cause_q;
    logic [31:0]     last_err_addr_q;
    logic            irq_err_q;

    logic [PAGE_W-1:0]  page;
    logic               status_hit, any_hit, rd, wr, is_idle;
    logic [SelW-1:0]    hit_idx;
    logic [NSLAVES-1:0] hit;
    logic               rbusy_sel, wbusy_sel, timed_out, rd_abort, wr_abort;
    logic [31:0]        rdata_slv;
    logic               unmap_ev, err_ev, clr;
    logic [1:0]         err_cause;
    logic [31:0]        err_addr;

    always_comb begin
        page       = bus.m_addr[31 -: PAGE_W];
        status_hit = (page == STATUS_PAGE);
        any_hit    = 1'b0;
        hit_idx    = '0;
        // Ascending scan with first-match latch: duplicated pages go to the lowest index.
        for (int i = 0; i < NSLAVES; i++) begin
            if (!status_hit && !any_hit && page == SLAVE_PAGES[i*PAGE_W +: PAGE_W]) begin
                any_hit = 1'b1;
                hit_idx = SelW'(i);
            end
        end
        hit       = '0;
        rbusy_sel = 1'b0;
        wbusy_sel = 1'b0;
        rdata_slv = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            hit[i] = any_hit && (hit_idx == SelW'(i));
            if (rsel_q == SelW'(i)) begin
                rbusy_sel = bus.s_rbusy[i];
                rdata_slv = bus.s_rdata[i*32 +: 32];
            end
            if (wsel_q == SelW'(i)) wbusy_sel = bus.s_wbusy[i];
        end
    end

    assign rd          = bus.m_rstrb;
    assign wr          = |bus.m_wmask;
    assign is_idle     = (state_q == StIdle);
    assign bus.s_sel   = hit;
    assign bus.s_rstrb = hit & {NSLAVES{rd && is_idle}};
    assign bus.s_wr    = hit & {NSLAVES{wr && is_idle}};

    assign timed_out   = (cnt_q == 16'(TIMEOUT - 1));
    assign rd_abort    = (state_q == StRwait) && rbusy_sel && timed_out;
    assign wr_abort    = (state_q == StWwait) && wbusy_sel && timed_out;
    assign bus.m_rbusy = (state_q == StRwait) && rbusy_sel && !timed_out;
    assign bus.m_wbusy = (state_q == StWwait) && wbusy_sel && !timed_out;

    always_comb begin
        if (rd_abort || rsel_q == SelErr) begin
            bus.m_rdata = ERR_DATA;
        end else if (rsel_q == SelStatus) begin
            bus.m_rdata = rsel_a2_q ? last_err_addr_q : {err_count_q, 14'b0, last_cause_q};
        end else if (rsel_q == SelUnmap) begin
            bus.m_rdata = 32'h0;
        end else begin
            bus.m_rdata = rdata_slv;
        end
    end

    assign unmap_ev  = is_idle && !status_hit && !any_hit && (rd || wr);
    assign err_ev    = unmap_ev || rd_abort || wr_abort;
    assign err_cause = rd_abort ? 2'd2 : (wr_abort ? 2'd3 : 2'd1);
    assign err_addr  = unmap_ev ? bus.m_addr : addr_q;
    assign clr       = status_hit && wr;
    assign irq_err   = irq_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= StIdle;
            rsel_q          <= SelUnmap;
            wsel_q          <= SelUnmap;
            rsel_a2_q       <= 1'b0;
            cnt_q           <= '0;
            addr_q          <= '0;
            err_count_q     <= '0;
            last_cause_q    <= '0;
            last_err_addr_q <= '0;
            irq_err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rd) begin
                        addr_q    <= bus.m_addr;
                        rsel_a2_q <= bus.m_addr[2];
                        if (status_hit) begin
                            rsel_q <= SelStatus;
                        end else if (any_hit) begin
                            rsel_q  <= hit_idx;
                            cnt_q   <= '0;
                            state_q <= StRwait;
                        end else begin
                            rsel_q <= SelUnmap;
                        end
                    end else if (wr) begin
                        addr_q <= bus.m_addr;
                        if (!status_hit && any_hit) begin
                            wsel_q  <= hit_idx;
                            cnt_q   <= '0;
                            state_q <= StWwait;
                        end
                    end
                end
                StRwait: begin
                    if (!rbusy_sel) begin
                        state_q <= StIdle;
                    end else if (timed_out) begin
                        rsel_q  <= SelErr;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                StWwait: begin
                    if (!wbusy_sel || timed_out) state_q <= StIdle;
                    else                         cnt_q   <= cnt_q + 16'd1;
                end
                default: state_q <= StIdle;
            endcase

            // A new error outranks a simultaneous status clear.
            if (err_ev) begin
                if (clr)                         err_count_q <= 16'd1;
                else if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
                last_cause_q    <= err_cause;
                last_err_addr_q <= err_addr;
                irq_err_q       <= 1'b1;
            end else if (clr) begin
                err_count_q     <= '0;
                last_cause_q    <= '0;
                last_err_addr_q <= '0;
                irq_err_q       <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bus_interconnect.sv
// Directed bench for bus_interconnect: decode, registered read mux, busy merge, timeouts,
// status page logging and asynchronous reset.
module tb_bus_interconnect;
    localparam int unsigned NS = 7;

    logic clk = 1'b0;
    logic rst;
    logic irq_err;
    int   errors = 0;
    int   checks = 0;

    bus_interconnect_if #(.NSLAVES(NS)) bus ();

    bus_interconnect #(.NSLAVES(NS), .TIMEOUT(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .irq_err (irq_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst         = 1'b1;
        bus.m_addr  = 32'h0;
        bus.m_wdata = 32'h0;
        bus.m_wmask = 4'h0;
        bus.m_rstrb = 1'b0;
        bus.s_rbusy = '0;
        bus.s_wbusy = '0;
        for (int i = 0; i < NS; i++) bus.s_rdata[i*32 +: 32] = 32'hA000_0000 + i;
        repeat (2) tick();
        checks++; if (bus.m_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h want 0", bus.m_rdata); end
        checks++; if (bus.m_rbusy !== 1'b0) begin errors++; $display("FAIL rst_rbusy: got %b want 0", bus.m_rbusy); end
        checks++; if (bus.m_wbusy !== 1'b0) begin errors++; $display("FAIL rst_wbusy: got %b want 0", bus.m_wbusy); end
        checks++; if (irq_err !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b want 0", irq_err); end
        rst         = 1'b0;
        bus.m_addr  = 32'h00FF0000;
        bus.m_rstrb = 1'b1;
        #1;
        checks++; if (bus.s_sel !== 7'b0) begin errors++; $display("FAIL status_sel: got %b want 0", bus.s_sel); end
        tick();
        bus.m_rstrb = 1'b0;
        #1;
        checks++; if (bus.m_rdata !== 32'h0) begin errors++; $display("FAIL rst_status: got %h want 0", bus.m_rdata); end
    endtask

    task automatic test_zero_wait_read();
        tick();
        bus.m_addr             = 32'h00440004;
        bus.m_rstrb            = 1'b1;
        bus.s_rdata[5*32 +: 32] = 32'h12345678;
        #1;
        checks++; if (bus.s_rstrb !== 7'b0100000) begin errors++; $display("FAIL zw_rstrb: got %b want 0100000", bus.s_rstrb); end
        checks++; if (bus.m_rbusy !== 1'b0) begin errors++; $display("FAIL zw_rbusy_strobe: got %b want 0", bus.m_rbusy); end
        tick();
        bus.m_rstrb = 1'b0;
        #1;
        checks++; if (bus.s_rstrb !== 7'b0) begin errors++; $display("FAIL zw_rstrb_off: got %b want 0", bus.s_rstrb); end
        checks++; if (bus.m_rdata !== 32'h12345678) begin errors++; $display("FAIL zw_rdata: got %h want 12345678", bus.m_rdata); end
        checks++; if (bus.m_rbusy !== 1'b0) begin errors++; $display("FAIL zw_rbusy: got %b want 0", bus.m_rbusy); end
        tick();
    endtask

    task automatic test_registered_select();
        bus.s_rdata[0 +: 32] = 32'h0BADF00D;
        bus.m_addr           = 32'h00000008;
        bus.m_rstrb          = 1'b1;
        tick();
        bus.m_rstrb = 1'b0;
        bus.m_addr  = 32'h00400000;
        #1;
        checks++; if (bus.m_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL rs_rdata: got %h want 0badf00d", bus.m_rdata); end
        checks++; if (bus.s_sel !== 7'b0000010) begin errors++; $display("FAIL rs_live_sel: got %b want 0000010", bus.s_sel); end
        tick();
        checks++; if (bus.m_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL rs_hold: got %h want 0badf00d", bus.m_rdata); end
    endtask

    task automatic test_slave_busy();
        bus.m_addr  = 32'h00010000;
        bus.m_rstrb = 1'b1;
        bus.s_rbusy = 7'b1000000;
        #1;
        checks++; if (bus.m_rbusy !== 1'b0) begin errors++; $display("FAIL sb_strobe_busy: got %b want 0", bus.m_rbusy); end
        for (int k = 1; k <= 5; k++) begin
            tick();
            bus.m_rstrb = 1'b0;
            #1;
            checks++; if (bus.m_rbusy !== 1'b1) begin errors++; $display("FAIL sb_busy_%0d: got %b want 1", k, bus.m_rbusy); end
        end
        tick();
        bus.s_rbusy = '0;
        #1;
        checks++; if (bus.m_rbusy !== 1'b0) begin errors++; $display("FAIL sb_release: got %b want 0", bus.m_rbusy); end
        checks++; if (bus.m_rdata !== 32'hA0000006) begin errors++; $display("FAIL sb_rdata: got %h want a0000006", bus.m_rdata); end
        tick();
        checks++; if (irq_err !== 1'b0) begin errors++; $display("FAIL sb_no_err: got %b want 0", irq_err); end
    endtask

    task automatic test_read_timeout();
        logic exp_busy;
        bus.m_addr  = 32'h00000010;
        bus.m_rstrb = 1'b1;
        bus.s_rbusy = 7'b0000001;
        for (int k = 1; k <= 8; k++) begin
            tick();
            bus.m_rstrb = 1'b0;
            #1;
            exp_busy = (k < 8);
            checks++; if (bus.m_rbusy !== exp_busy) begin errors++; $display("FAIL rt_busy_%0d: got %b want %b", k, bus.m_rbusy, exp_busy); end
        end
        checks++; if (bus.m_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rt_abort_data: got %h want deadbeef", bus.m_rdata); end
        checks++; if (irq_err !== 1'b0) begin errors++; $display("FAIL rt_irq_early: got %b want 0", irq_err); end
        tick();
        checks++; if (irq_err !== 1'b1) begin errors++; $display("FAIL rt_irq: got %b want 1", irq_err); end
        checks++; if (bus.m_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rt_hold_data: got %h want deadbeef", bus.m_rdata); end
        bus.s_rbusy = '0;
        bus.m_addr  = 32'h00FF0000;
        bus.m_rstrb = 1'b1;
        tick();
        bus.m_addr = 32'h00FF0004;
        #1;
        checks++; if (bus.m_rdata !== 32'h00010002) begin errors++; $display("FAIL rt_word0: got %h want 00010002", bus.m_rdata); end
        tick();
        bus.m_rstrb = 1'b0;
        #1;
        checks++; if (bus.m_rdata !== 32'h00000010) begin errors++; $display("FAIL rt_word1: got %h want 00000010", bus.m_rdata); end
    endtask

    task automatic test_unmapped_write();
        bus.m_addr  = 32'h00FF0000;
        bus.m_wmask = 4'hF;
        tick();
        bus.m_wmask = 4'h0;
        #1;
        checks++; if (irq_err !== 1'b0) begin errors++; $display("FAIL uw_clear_pre: got %b want 0", irq_err); end
        bus.m_addr  = 32'h12340000;
        bus.m_wmask = 4'hF;
        #1;
        checks++; if (bus.s_wr !== 7'b0) begin errors++; $display("FAIL uw_s_wr: got %b want 0", bus.s_wr); end
        tick();
        bus.m_wmask = 4'h0;
        #1;
        checks++; if (irq_err !== 1'b1) begin errors++; $display("FAIL uw_irq: got %b want 1", irq_err); end
        checks++; if (bus.m_wbusy !== 1'b0) begin errors++; $display("FAIL uw_wbusy: got %b want 0", bus.m_wbusy); end
        bus.m_addr  = 32'h00FF0000;
        bus.m_rstrb = 1'b1;
        tick();
        bus.m_addr = 32'h00FF0004;
        #1;
        checks++; if (bus.m_rdata !== 32'h00010001) begin errors++; $display("FAIL uw_word0: got %h want 00010001", bus.m_rdata); end
        tick();
        bus.m_addr = 32'h12348000;
        #1;
        checks++; if (bus.m_rdata !== 32'h12340000) begin errors++; $display("FAIL uw_word1: got %h want 12340000", bus.m_rdata); end
        tick();
        bus.m_rstrb = 1'b0;
        #1;
        checks++; if (bus.m_rdata !== 32'h0) begin errors++; $display("FAIL ur_rdata: got %h want 0", bus.m_rdata); end
        bus.m_addr  = 32'h00FF0000;
        bus.m_wmask = 4'hF;
        tick();
        bus.m_wmask = 4'h0;
        bus.m_rstrb = 1'b1;
        #1;
        checks++; if (irq_err !== 1'b0) begin errors++; $display("FAIL uw_clear_irq: got %b want 0", irq_err); end
        tick();
        bus.m_rstrb = 1'b0;
        #1;
        checks++; if (bus.m_rdata !== 32'h0) begin errors++; $display("FAIL uw_clear_word0: got %h want 0", bus.m_rdata); end
    endtask

    task automatic test_reset_during_wait();
        bus.m_addr  = 32'h00420000;
        bus.m_rstrb = 1'b1;
        tick();
        bus.m_rstrb = 1'b0;
        tick();
        bus.m_addr  = 32'h55550000;
        bus.m_wmask = 4'hF;
        tick();
        bus.m_addr  = 32'h00410000;
        bus.s_wbusy = 7'b0000100;
        #1;
        checks++; if (bus.s_wr !== 7'b0000100) begin errors++; $display("FAIL rw_s_wr: got %b want 0000100", bus.s_wr); end
        tick();
        bus.m_wmask = 4'h0;
        #1;
        checks++; if (bus.m_wbusy !== 1'b1) begin errors++; $display("FAIL rw_wbusy: got %b want 1", bus.m_wbusy); end
        checks++; if (irq_err !== 1'b1) begin errors++; $display("FAIL rw_irq_pre: got %b want 1", irq_err); end
        checks++; if (bus.m_rdata !== 32'hA0000003) begin errors++; $display("FAIL rw_rdata_pre: got %h want a0000003", bus.m_rdata); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (bus.m_wbusy !== 1'b0) begin errors++; $display("FAIL rw_async_wbusy: got %b want 0", bus.m_wbusy); end
        checks++; if (irq_err !== 1'b0) begin errors++; $display("FAIL rw_async_irq: got %b want 0", irq_err); end
        checks++; if (bus.m_rdata !== 32'h0) begin errors++; $display("FAIL rw_async_rdata: got %h want 0", bus.m_rdata); end
        tick();
        rst         = 1'b0;
        bus.s_wbusy = '0;
        bus.m_addr  = 32'h00FF0000;
        bus.m_rstrb = 1'b1;
        tick();
        bus.m_rstrb = 1'b0;
        #1;
        checks++; if (bus.m_rdata !== 32'h0) begin errors++; $display("FAIL rw_no_log: got %h want 0", bus.m_rdata); end
    endtask

    task automatic test_write_timeout();
        logic exp_busy;
        bus.m_addr  = 32'h00430000;
        bus.m_wmask = 4'hF;
        bus.s_wbusy = 7'b0010000;
        for (int k = 1; k <= 8; k++) begin
            tick();
            bus.m_wmask = 4'h0;
            #1;
            exp_busy = (k < 8);
            checks++; if (bus.m_wbusy !== exp_busy) begin errors++; $display("FAIL wt_busy_%0d: got %b want %b", k, bus.m_wbusy, exp_busy); end
        end
        tick();
        checks++; if (irq_err !== 1'b1) begin errors++; $display("FAIL wt_irq: got %b want 1", irq_err); end
        bus.s_wbusy = '0;
        bus.m_addr  = 32'h00FF0000;
        bus.m_rstrb = 1'b1;
        tick();
        bus.m_rstrb = 1'b0;
        #1;
        checks++; if (bus.m_rdata !== 32'h00010003) begin errors++; $display("FAIL wt_word0: got %h want 00010003", bus.m_rdata); end
    endtask

    initial begin
        test_reset();
        test_zero_wait_read();
        test_registered_select();
        test_slave_busy();
        test_read_timeout();
        test_unmapped_write();
        test_reset_during_wait();
        test_write_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
